// File: rtl/jtframe_cen_sched.sv
// Fractional clock-enable scheduler: cen/cenb at f_clk*n/m, gated by PLL lock, with ratio updates.
// Optional monitor outputs (lost, cen_cnt) exist only when JTFRAME_CEN_MON_EN is defined.
module jtframe_cen_sched #(
  parameter int W         = 10,
  parameter int LOCK_WAIT = 16,
  parameter int N_INIT    = 1,
  parameter int M_INIT    = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         locked,
  input  logic [W-1:0] n,
  input  logic [W-1:0] m,
  input  logic         upd,
  output logic         upd_ack,
  output logic         err,
  output logic         run,
  output logic         cen,
  output logic         cenb
`ifdef JTFRAME_CEN_MON_EN
  ,
  output logic         lost,
  output logic [15:0]  cen_cnt
`endif
);

  localparam int CW = (LOCK_WAIT > 1) ? $clog2(LOCK_WAIT) : 1;

  localparam logic [1:0] StWaitLock = 2'd0;
  localparam logic [1:0] StSettle   = 2'd1;
  localparam logic [1:0] StRun      = 2'd2;

  logic [1:0]   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W:0]   acc_q, acc_d;
  logic [W-1:0] act_n_q, act_n_d, act_m_q, act_m_d;
  logic         pend_q, pend_d;
  logic [W-1:0] pend_n_q, pend_n_d, pend_m_q, pend_m_d;
  logic         cen_q, cenb_q, ack_q, err_q;

  logic         active, wrap, half, apply, req_ok;
  logic [W:0]   sum, acc_step, half_m;

  always_comb begin
    active   = (state_q == StRun) && locked;
    sum      = acc_q + {1'b0, act_n_q};
    half_m   = {2'b00, act_m_q[W-1:1]};
    wrap     = active && (sum >= {1'b0, act_m_q});
    acc_step = wrap ? sum - {1'b0, act_m_q} : sum;
    half     = active && !wrap && (acc_q < half_m) && (sum >= half_m);
    // In RUN a new ratio only takes effect on a wrap so no interval is cut short
    apply    = pend_q && ((state_q == StRun) ? wrap : 1'b1);
    req_ok   = (n != '0) && ({n, 1'b0} <= {1'b0, m});
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    act_n_d  = act_n_q;
    act_m_d  = act_m_q;
    pend_d   = pend_q;
    pend_n_d = pend_n_q;
    pend_m_d = pend_m_q;
    acc_d    = '0;

    if (active) begin
      acc_d = acc_step;
    end
    if (apply) begin
      act_n_d = pend_n_q;
      act_m_d = pend_m_q;
      if (acc_d >= {1'b0, pend_m_q}) begin
        acc_d = '0;
      end
    end

    if (upd && req_ok) begin
      pend_d   = 1'b1;
      pend_n_d = n;
      pend_m_d = m;
    end else if (apply) begin
      pend_d = 1'b0;
    end

    case (state_q)
      StWaitLock: begin
        cnt_d = '0;
        if (locked) begin
          state_d = StSettle;
        end
      end
      StSettle: begin
        if (!locked) begin
          state_d = StWaitLock;
          cnt_d   = '0;
        end else if (cnt_q == CW'(LOCK_WAIT - 1)) begin
          state_d = StRun;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StRun: begin
        if (!locked) begin
          state_d = StWaitLock;
        end
      end
      default: begin
        state_d = StWaitLock;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StWaitLock;
      cnt_q    <= '0;
      acc_q    <= '0;
      act_n_q  <= W'(N_INIT);
      act_m_q  <= W'(M_INIT);
      pend_q   <= 1'b0;
      pend_n_q <= '0;
      pend_m_q <= '0;
      cen_q    <= 1'b0;
      cenb_q   <= 1'b0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      act_n_q  <= act_n_d;
      act_m_q  <= act_m_d;
      pend_q   <= pend_d;
      pend_n_q <= pend_n_d;
      pend_m_q <= pend_m_d;
      cen_q    <= wrap;
      cenb_q   <= half;
      ack_q    <= apply;
      err_q    <= upd && !req_ok;
    end
  end

  assign run     = (state_q == StRun);
  assign cen     = cen_q;
  assign cenb    = cenb_q;
  assign upd_ack = ack_q;
  assign err     = err_q;

`ifdef JTFRAME_CEN_MON_EN
  logic        lost_q;
  logic [15:0] cen_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      lost_q    <= 1'b0;
      cen_cnt_q <= '0;
    end else begin
      lost_q    <= lost_q | ((state_q == StRun) && !locked);
      cen_cnt_q <= cen_cnt_q + 16'(cen_q);
    end
  end

  assign lost    = lost_q;
  assign cen_cnt = cen_cnt_q;
`endif

endmodule

// File: tb/tb_jtframe_cen_sched.sv
// Randomized self-checking bench for jtframe_cen_sched against an integer reference model.
module tb_jtframe_cen_sched;
  localparam int W = 10;
  localparam int LOCK_WAIT = 16;

  logic clk = 1'b0;
  logic rst, locked, upd;
  logic [W-1:0] n, m;
  logic upd_ack, err, run, cen, cenb;
`ifdef JTFRAME_CEN_MON_EN
  logic lost;
  logic [15:0] cen_cnt;
`endif

  jtframe_cen_sched #(.W(W), .LOCK_WAIT(LOCK_WAIT), .N_INIT(1), .M_INIT(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .locked  (locked),
    .n       (n),
    .m       (m),
    .upd     (upd),
    .upd_ack (upd_ack),
    .err     (err),
    .run     (run),
    .cen     (cen),
    .cenb    (cenb)
`ifdef JTFRAME_CEN_MON_EN
    ,
    .lost    (lost),
    .cen_cnt (cen_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: lock tracking, integer phase accumulator, pending ratio
  bit mdl_running, mdl_settling;
  int mdl_locked_cnt, mdl_acc, mdl_n, mdl_m;
  bit mdl_pend;
  int mdl_pn, mdl_pm;
  bit e_cen, e_cenb, e_ack, e_err, e_lost;
  int e_cnt;

  task automatic model_step();
    bit wrap, half, apply, ok;
    int s, nacc;
    if (rst) begin
      mdl_running = 0; mdl_settling = 0; mdl_locked_cnt = 0; mdl_acc = 0;
      mdl_n = 1; mdl_m = 8; mdl_pend = 0;
      e_cen = 0; e_cenb = 0; e_ack = 0; e_err = 0; e_lost = 0; e_cnt = 0;
      return;
    end
    wrap = 0; half = 0; nacc = 0;
    e_cnt = (e_cnt + int'(e_cen)) % 65536;
    if (mdl_running && !locked) e_lost = 1;
    if (mdl_running && locked) begin
      s = mdl_acc + mdl_n;
      wrap = (s >= mdl_m);
      nacc = wrap ? s - mdl_m : s;
      half = !wrap && (mdl_acc < mdl_m / 2) && (s >= mdl_m / 2);
    end
    apply = mdl_pend && (mdl_running ? wrap : 1'b1);
    ok = (int'(n) != 0) && (2 * int'(n) <= int'(m));
    e_err = upd && !ok;
    e_ack = apply;
    e_cen = wrap;
    e_cenb = half;
    if (apply) begin
      mdl_n = mdl_pn; mdl_m = mdl_pm;
      if (nacc >= mdl_m) nacc = 0;
    end
    if (upd && ok) begin
      mdl_pend = 1; mdl_pn = int'(n); mdl_pm = int'(m);
    end else if (apply) begin
      mdl_pend = 0;
    end
    mdl_acc = nacc;
    if (!locked) begin
      mdl_running = 0; mdl_settling = 0; mdl_acc = 0;
    end else if (mdl_running) begin
      // stays running
    end else if (!mdl_settling) begin
      mdl_settling = 1; mdl_locked_cnt = 0;
    end else begin
      mdl_locked_cnt++;
      if (mdl_locked_cnt == LOCK_WAIT) begin
        mdl_settling = 0; mdl_running = 1; mdl_acc = 0;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    check("run", 32'(run), 32'(mdl_running));
    check("cen", 32'(cen), 32'(e_cen));
    check("cenb", 32'(cenb), 32'(e_cenb));
    check("upd_ack", 32'(upd_ack), 32'(e_ack));
    check("err", 32'(err), 32'(e_err));
`ifdef JTFRAME_CEN_MON_EN
    check("lost", 32'(lost), 32'(e_lost));
    check("cen_cnt", 32'(cen_cnt), 32'(e_cnt));
`endif
    upd = 1'b0;
  endtask

  task automatic request(input int rn, input int rm);
    n = W'(rn);
    m = W'(rm);
    upd = 1'b1;
    step();
  endtask

  initial begin
    int edges, first_cen, first_cenb, second_cen, c_cen, c_cenb, c_both, last_cen, prev_cen;
    rst = 1'b1; locked = 1'b0; upd = 1'b0; n = '0; m = '0;
    repeat (3) step();
    check("reset_outputs", {27'd0, upd_ack, err, run, cen, cenb}, 32'd0);

    // Lock from reset: 1 cycle to leave WAIT_LOCK, LOCK_WAIT settle cycles
    rst = 1'b0; locked = 1'b1;
    edges = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      edges++;
      if (run) break;
    end
    check("run_rise_cycle", 32'(edges), 32'(LOCK_WAIT + 1));

    first_cen = -1; first_cenb = -1; second_cen = -1;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (cenb && first_cenb < 0) first_cenb = k;
      if (cen && first_cen >= 0 && second_cen < 0) second_cen = k;
      if (cen && first_cen < 0) first_cen = k;
    end
    check("first_cenb_k", 32'(first_cenb), 32'd4);
    check("first_cen_k", 32'(first_cen), 32'd8);
    check("second_cen_k", 32'(second_cen), 32'd16);

    // 3/8 ratio: 300 of each over 800 cycles, never coincident
    request(3, 8);
    repeat (30) step();
    c_cen = 0; c_cenb = 0; c_both = 0;
    for (int i = 0; i < 800; i++) begin
      step();
      c_cen += int'(cen);
      c_cenb += int'(cenb);
      c_both += int'(cen && cenb);
    end
    check("cen_count_3_8", 32'(c_cen), 32'd300);
    check("cenb_count_3_8", 32'(c_cenb), 32'd300);
    check("cen_cenb_overlap", 32'(c_both), 32'd0);

    // Mid-interval switch to 1/4
    repeat (3) step();
    request(1, 4);
    last_cen = -1; prev_cen = -1;
    for (int i = 0; i < 40; i++) begin
      step();
      if (cen) begin prev_cen = last_cen; last_cen = i; end
    end
    check("period_1_4", 32'(last_cen - prev_cen), 32'd4);

    // Invalid requests: 2n>m and n=0
    request(5, 8);
    request(0, 8);
    c_cen = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      c_cen += int'(cen);
    end
    check("period_after_err", 32'(c_cen), 32'd10);

    // One-cycle lock drop
    locked = 1'b0; step();
    check("run_after_drop", 32'(run), 32'd0);
    locked = 1'b1;
    repeat (40) step();
`ifdef JTFRAME_CEN_MON_EN
    check("lost_sticky", 32'(lost), 32'd1);
`endif

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      int rm;
      rst = ($urandom_range(999) == 0);
      locked = ($urandom_range(199) != 0);
      rm = $urandom_range(60, 1);
      if ($urandom_range(29) == 0) begin
        n = W'($urandom_range(rm / 2 + 1, 0));
        m = W'(rm);
        upd = 1'b1;
      end
      step();
    end

    // Reset while an update is pending
    rst = 1'b0; locked = 1'b1;
    repeat (40) step();
    request(2, 9);
    rst = 1'b1; step();
    check("rst_clears_outputs", {27'd0, upd_ack, err, run, cen, cenb}, 32'd0);
    rst = 1'b0;
    c_cen = 0;
    for (int i = 0; i < 60; i++) begin
      step();
      c_cen += int'(upd_ack);
    end
    check("no_ack_after_rst", 32'(c_cen), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
